dlsc_pcie_inbound_decode_er: RTL and testbench

// Parametrised inbound request decoder for the PCIe request path: parses 3/4-DW request TLP headers

---
 rtl/dlsc_pcie_inbound_decode_er.sv | 272 +++++++++++++++++++++++++++
 tb/tb_dlsc_pcie_inbound_decode_er.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlsc_pcie_inbound_decode_er.sv
// Inbound PCIe request decoder: parses 3/4-DW request headers, issues BAR translation requests,
// forwards headers, completer IDs and write payload, and reports rejected TLPs on an error channel.
module dlsc_pcie_inbound_decode_er #(
    parameter int ADDR    = 32,
    parameter int BARS    = 7,
    parameter int MAX_LEN = 256,
    parameter bit SWAP    = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BARS-1:0] bar_en,
    output logic            trans_req,
    output logic [2:0]      trans_req_bar,
    output logic [63:2]     trans_req_addr,
    output logic            trans_req_64,
    input  logic            trans_ack,
    input  logic [ADDR-1:2] trans_ack_addr,
    output logic            rx_ready,
    input  logic            rx_valid,
    input  logic [31:0]     rx_data,
    input  logic            rx_last,
    input  logic            rx_err,
    input  logic [BARS-1:0] rx_bar,
    input  logic            tlp_h_ready,
    output logic            tlp_h_valid,
    output logic            tlp_h_np,
    output logic            tlp_h_write,
    output logic            tlp_h_mem,
    output logic [ADDR-1:2] tlp_h_addr,
    output logic [9:0]      tlp_h_len,
    output logic [3:0]      tlp_h_be_first,
    output logic [3:0]      tlp_h_be_last,
    input  logic            tlp_id_ready,
    output logic            tlp_id_valid,
    output logic            tlp_id_write,
    output logic [28:0]     tlp_id_data,
    input  logic            tlp_d_ready,
    output logic            tlp_d_valid,
    output logic            tlp_d_last,
    output logic [31:0]     tlp_d_data,
    output logic [3:0]      tlp_d_strb,
    input  logic            err_ready,
    output logic            err_valid,
    output logic [2:0]      err_code,
    output logic            err_np,
    output logic [28:0]     err_id,
    output logic [15:0]     err_count
);

    typedef enum logic [2:0] {ST_H0, ST_H1, ST_H2, ST_H3, ST_DATA, ST_FLUSH} state_t;

    localparam logic [10:0] MAX_LEN_L = 11'(MAX_LEN);

    function automatic logic [2:0] bar_encode(input logic [BARS-1:0] hit);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = BARS - 1; i >= 0; i--) begin
            if (hit[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [31:0] byte_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    state_t      st_q, st_d;
    logic        fmt4_q, fmt4_d, write_q, write_d, mem_q, mem_d, io_q, io_d, cfg_q, cfg_d;
    logic [2:0]  tc_q, tc_d, bar_q, bar_d;
    logic [1:0]  attr_q, attr_d;
    logic [9:0]  len_q, len_d;
    logic [3:0]  be_first_q, be_first_d, be_last_q, be_last_d;
    logic        first_q, first_d;
    logic        trans_req_q, trans_req_d, trans_64_q, trans_64_d;
    logic [2:0]  trans_bar_q, trans_bar_d;
    logic [63:2] trans_addr_q, trans_addr_d;
    logic        h_np_q, h_np_d, h_write_q, h_write_d, h_mem_q, h_mem_d;
    logic [9:0]  h_len_q, h_len_d;
    logic [3:0]  h_bef_q, h_bef_d, h_bel_q, h_bel_d;
    logic        err_valid_q, err_valid_d, err_np_q, err_np_d;
    logic [2:0]  err_code_q, err_code_d;
    logic [28:0] err_id_q, err_id_d;
    logic [15:0] err_count_q, err_count_d;

    logic        h0_wr, h0_mem, h0_io, h0_cfg, h0_fail;
    logic [2:0]  h0_code;
    logic [10:0] h0_len_eff;
    logic        np;

    // First header DW classification and rejection checks, highest priority first
    always_comb begin
        h0_wr      = rx_data[30];
        h0_mem     = (rx_data[28:24] == 5'b00000);
        h0_io      = (rx_data[28:24] == 5'b00010);
        h0_cfg     = (rx_data[28:25] == 4'b0010);
        h0_len_eff = (rx_data[9:0] == 10'd0) ? 11'd1024 : {1'b0, rx_data[9:0]};
        h0_fail    = 1'b1;
        h0_code    = 3'd0;
        if (rx_err)                                 h0_code = 3'd0;
        else if (rx_data[14])                       h0_code = 3'd1;
        else if (!(h0_mem || h0_io || h0_cfg))      h0_code = 3'd2;
        else if (h0_wr && (h0_len_eff > MAX_LEN_L)) h0_code = 3'd3;
        else if (!h0_cfg && ((rx_bar & ~bar_en) != '0)) h0_code = 3'd4;
        else                                        h0_fail = 1'b0;
    end

    assign np = !write_q || cfg_q || io_q;

    always_comb begin
        st_d = st_q;
        fmt4_d = fmt4_q; write_d = write_q; mem_d = mem_q; io_d = io_q; cfg_d = cfg_q;
        tc_d = tc_q; attr_d = attr_q; len_d = len_q; bar_d = bar_q;
        be_first_d = be_first_q; be_last_d = be_last_q; first_d = first_q;
        trans_req_d = trans_req_q; trans_bar_d = trans_bar_q;
        trans_addr_d = trans_addr_q; trans_64_d = trans_64_q;
        h_np_d = h_np_q; h_write_d = h_write_q; h_mem_d = h_mem_q;
        h_len_d = h_len_q; h_bef_d = h_bef_q; h_bel_d = h_bel_q;
        err_valid_d = err_valid_q; err_code_d = err_code_q; err_np_d = err_np_q;
        err_id_d = err_id_q; err_count_d = err_count_q;
        rx_ready = 1'b0;
        tlp_id_valid = 1'b0;
        tlp_d_valid = 1'b0;

        // Clear first so a set from the header states below takes precedence
        if (trans_req_q && trans_ack && tlp_h_ready) trans_req_d = 1'b0;
        if (err_valid_q && err_ready) err_valid_d = 1'b0;

        case (st_q)
            ST_H0: begin
                rx_ready = !err_valid_q;
                if (rx_valid && !err_valid_q) begin
                    fmt4_d  = rx_data[29];
                    write_d = h0_wr;
                    mem_d   = h0_mem;
                    io_d    = h0_io;
                    cfg_d   = h0_cfg;
                    tc_d    = rx_data[22:20];
                    attr_d  = rx_data[13:12];
                    len_d   = rx_data[9:0];
                    bar_d   = bar_encode(rx_bar);
                    if (h0_fail) begin
                        err_code_d = h0_code;
                        err_np_d   = !h0_wr || h0_cfg || h0_io;
                        err_id_d   = '0;
                        first_d    = 1'b1;
                        if (rx_last) begin
                            err_valid_d = 1'b1;
                            err_count_d = sat_inc(err_count_q);
                        end else begin
                            st_d = ST_FLUSH;
                        end
                    end else begin
                        st_d = ST_H1;
                    end
                end
            end
            ST_H1: begin
                rx_ready     = tlp_id_ready || !np;
                tlp_id_valid = rx_valid && np;
                if (rx_valid && rx_ready) begin
                    be_last_d  = rx_data[7:4];
                    be_first_d = rx_data[3:0];
                    st_d       = ST_H2;
                end
            end
            ST_H2: begin
                rx_ready = !trans_req_q;
                if (rx_valid && !trans_req_q) begin
                    h_np_d      = np;
                    h_write_d   = write_q;
                    h_mem_d     = mem_q;
                    h_len_d     = len_q;
                    h_bef_d     = be_first_q;
                    h_bel_d     = be_last_q;
                    trans_bar_d = cfg_q ? 3'd7 : bar_q;
                    trans_64_d  = fmt4_q;
                    first_d     = 1'b1;
                    if (fmt4_q) begin
                        trans_addr_d = {rx_data, 30'd0};
                        st_d         = ST_H3;
                    end else begin
                        trans_addr_d = cfg_q ? {52'd0, rx_data[11:2]} : {32'd0, rx_data[31:2]};
                        trans_req_d  = 1'b1;
                        st_d         = write_q ? ST_DATA : ST_H0;
                    end
                end
            end
            ST_H3: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    trans_addr_d[31:2] = rx_data[31:2];
                    trans_req_d        = 1'b1;
                    st_d               = write_q ? ST_DATA : ST_H0;
                end
            end
            ST_DATA: begin
                rx_ready    = tlp_d_ready;
                tlp_d_valid = rx_valid;
                if (rx_valid && tlp_d_ready) begin
                    first_d = 1'b0;
                    if (rx_last) st_d = ST_H0;
                end
            end
            ST_FLUSH: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (first_q) err_id_d = {tc_q, attr_q, rx_data[31:8]};
                    first_d = 1'b0;
                    if (rx_last) begin
                        err_valid_d = 1'b1;
                        err_count_d = sat_inc(err_count_q);
                        st_d        = ST_H0;
                    end
                end
            end
            default: st_d = ST_H0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= ST_H0;
            trans_req_q <= 1'b0;
            err_valid_q <= 1'b0;
            err_count_q <= 16'd0;
        end else begin
            st_q        <= st_d;
            trans_req_q <= trans_req_d;
            err_valid_q <= err_valid_d;
            err_count_q <= err_count_d;
        end
    end

    always_ff @(posedge clk) begin
        fmt4_q <= fmt4_d; write_q <= write_d; mem_q <= mem_d; io_q <= io_d; cfg_q <= cfg_d;
        tc_q <= tc_d; attr_q <= attr_d; len_q <= len_d; bar_q <= bar_d;
        be_first_q <= be_first_d; be_last_q <= be_last_d; first_q <= first_d;
        trans_bar_q <= trans_bar_d; trans_addr_q <= trans_addr_d; trans_64_q <= trans_64_d;
        h_np_q <= h_np_d; h_write_q <= h_write_d; h_mem_q <= h_mem_d;
        h_len_q <= h_len_d; h_bef_q <= h_bef_d; h_bel_q <= h_bel_d;
        err_code_q <= err_code_d; err_np_q <= err_np_d; err_id_q <= err_id_d;
    end

    assign trans_req      = trans_req_q;
    assign trans_req_bar  = trans_bar_q;
    assign trans_req_addr = trans_addr_q;
    assign trans_req_64   = trans_64_q;
    assign tlp_h_valid    = trans_req_q && trans_ack;
    assign tlp_h_np       = h_np_q;
    assign tlp_h_write    = h_write_q;
    assign tlp_h_mem      = h_mem_q;
    assign tlp_h_addr     = trans_ack_addr;
    assign tlp_h_len      = h_len_q;
    assign tlp_h_be_first = h_bef_q;
    assign tlp_h_be_last  = h_bel_q;
    assign tlp_id_write   = write_q;
    assign tlp_id_data    = {tc_q, attr_q, rx_data[31:8]};
    // Single-DW payloads take be_first because the first-beat test wins
    assign tlp_d_last     = rx_last;
    assign tlp_d_data     = SWAP ? byte_swap(rx_data) : rx_data;
    assign tlp_d_strb     = first_q ? be_first_q : (rx_last ? be_last_q : 4'hF);
    assign err_valid      = err_valid_q;
    assign err_code       = err_code_q;
    assign err_np         = err_np_q;
    assign err_id         = err_id_q;
    assign err_count      = err_count_q;

endmodule

// File: tb/tb_dlsc_pcie_inbound_decode_er.sv
// Scoreboard bench for dlsc_pcie_inbound_decode_er: directed TLPs push expected records,
// per-channel monitors pop and compare on every output handshake.
`timescale 1ns/1ps
module tb_dlsc_pcie_inbound_decode_er;

    localparam int BARS = 7;
    localparam logic [29:0] XLATE = 30'h0F00_0000;

    typedef struct packed {
        logic np, wr, mem;
        logic [29:0] addr;
        logic [9:0]  len;
        logic [3:0]  bef, bel;
        logic [2:0]  bar;
        logic [61:0] raddr;
        logic        is64;
    } h_t;
    typedef struct packed { logic wr; logic [28:0] data; } id_t;
    typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } d_t;
    typedef struct packed { logic [2:0] code; logic np; logic [28:0] id; logic [15:0] cnt; } e_t;

    logic clk = 1'b0;
    logic rst;
    logic [BARS-1:0] bar_en, rx_bar;
    logic trans_req, trans_req_64, trans_ack;
    logic [2:0] trans_req_bar;
    logic [63:2] trans_req_addr;
    logic [31:2] trans_ack_addr;
    logic rx_ready, rx_valid, rx_last, rx_err;
    logic [31:0] rx_data;
    logic tlp_h_ready, tlp_h_valid, tlp_h_np, tlp_h_write, tlp_h_mem;
    logic [31:2] tlp_h_addr;
    logic [9:0] tlp_h_len;
    logic [3:0] tlp_h_be_first, tlp_h_be_last;
    logic tlp_id_ready, tlp_id_valid, tlp_id_write;
    logic [28:0] tlp_id_data;
    logic tlp_d_ready, tlp_d_valid, tlp_d_last;
    logic [31:0] tlp_d_data;
    logic [3:0] tlp_d_strb;
    logic err_ready, err_valid, err_np;
    logic [2:0] err_code;
    logic [28:0] err_id;
    logic [15:0] err_count;

    int checks = 0;
    int failures = 0;
    int beats_acc = 0;
    int h_hs_cnt = 0;
    int ack_dly = 1;
    logic [31:0] pkt [0:7];
    h_t  h_q[$];
    id_t id_q[$];
    d_t  d_q[$];
    e_t  e_q[$];
    h_t  mh_act, mh_exp;
    id_t mi_act, mi_exp;
    d_t  md_act, md_exp;
    e_t  me_act, me_exp;

    always #5 clk = ~clk;

    dlsc_pcie_inbound_decode_er #(.ADDR(32), .BARS(BARS), .MAX_LEN(256), .SWAP(1'b1)) dut (
        .clk(clk), .rst(rst), .bar_en(bar_en),
        .trans_req(trans_req), .trans_req_bar(trans_req_bar), .trans_req_addr(trans_req_addr),
        .trans_req_64(trans_req_64), .trans_ack(trans_ack), .trans_ack_addr(trans_ack_addr),
        .rx_ready(rx_ready), .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last),
        .rx_err(rx_err), .rx_bar(rx_bar),
        .tlp_h_ready(tlp_h_ready), .tlp_h_valid(tlp_h_valid), .tlp_h_np(tlp_h_np),
        .tlp_h_write(tlp_h_write), .tlp_h_mem(tlp_h_mem), .tlp_h_addr(tlp_h_addr),
        .tlp_h_len(tlp_h_len), .tlp_h_be_first(tlp_h_be_first), .tlp_h_be_last(tlp_h_be_last),
        .tlp_id_ready(tlp_id_ready), .tlp_id_valid(tlp_id_valid), .tlp_id_write(tlp_id_write),
        .tlp_id_data(tlp_id_data),
        .tlp_d_ready(tlp_d_ready), .tlp_d_valid(tlp_d_valid), .tlp_d_last(tlp_d_last),
        .tlp_d_data(tlp_d_data), .tlp_d_strb(tlp_d_strb),
        .err_ready(err_ready), .err_valid(err_valid), .err_code(err_code), .err_np(err_np),
        .err_id(err_id), .err_count(err_count)
    );

    function automatic logic [31:0] hdr0(input logic f4, input logic wr, input logic [4:0] ty,
                                         input logic [2:0] tc, input logic ep,
                                         input logic [1:0] attr, input logic [9:0] len);
        return {1'b0, wr, f4, ty, 1'b0, tc, 4'b0, 1'b0, ep, attr, 2'b0, len};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_h(input logic np, input logic wr, input logic mem, input logic [61:0] raddr,
                          input logic [9:0] len, input logic [3:0] bef, input logic [3:0] bel,
                          input logic [2:0] bar, input logic is64);
        h_t r;
        r.np = np; r.wr = wr; r.mem = mem; r.addr = raddr[29:0] ^ XLATE; r.len = len;
        r.bef = bef; r.bel = bel; r.bar = bar; r.raddr = raddr; r.is64 = is64;
        h_q.push_back(r);
    endtask

    task automatic push_id(input logic wr, input logic [28:0] data);
        id_q.push_back({wr, data});
    endtask

    task automatic push_d(input logic [31:0] data, input logic [3:0] strb, input logic last);
        d_q.push_back({data, strb, last});
    endtask

    task automatic push_e(input logic [2:0] code, input logic np, input logic [28:0] id,
                          input logic [15:0] cnt);
        e_q.push_back({code, np, id, cnt});
    endtask

    task automatic send_pkt(input int n, input logic [BARS-1:0] bar, input logic err0);
        for (int i = 0; i < n; i++) begin
            int k;
            rx_valid = 1'b1; rx_data = pkt[i]; rx_last = (i == n - 1);
            rx_err = err0 && (i == 0); rx_bar = bar;
            k = 0;
            @(negedge clk);
            while (!rx_ready && k < 2000) begin k++; @(negedge clk); end
            if (!rx_ready) begin
                checks++; failures++;
                $display("FAIL rx_timeout beat=%0d actual=stalled required=accepted", i);
            end
            @(posedge clk); #1;
            beats_acc++;
        end
        rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0;
    endtask

    // Translation responder: answers each request after ack_dly cycles
    initial begin
        trans_ack = 1'b0; trans_ack_addr = '0;
        forever begin
            @(posedge clk); #1;
            if (trans_req && !trans_ack) begin
                int k;
                for (int i = 0; i < ack_dly; i++) @(posedge clk);
                #1;
                trans_ack = 1'b1;
                trans_ack_addr = trans_req_addr[31:2] ^ XLATE;
                k = 0;
                @(negedge clk);
                while (!tlp_h_ready && k < 2000) begin k++; @(negedge clk); end
                @(posedge clk); #1;
                trans_ack = 1'b0;
            end
        end
    end

    // Monitors
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tlp_h_valid && tlp_h_ready) begin
                    h_hs_cnt++;
                    mh_act.np = tlp_h_np; mh_act.wr = tlp_h_write; mh_act.mem = tlp_h_mem;
                    mh_act.addr = tlp_h_addr; mh_act.len = tlp_h_len;
                    mh_act.bef = tlp_h_be_first; mh_act.bel = tlp_h_be_last;
                    mh_act.bar = trans_req_bar; mh_act.raddr = trans_req_addr; mh_act.is64 = trans_req_64;
                    checks++;
                    if (h_q.size() == 0) begin
                        failures++; $display("FAIL hdr actual=%h required=none", mh_act);
                    end else begin
                        mh_exp = h_q.pop_front();
                        if (mh_act !== mh_exp) begin
                            failures++; $display("FAIL hdr actual=%h required=%h", mh_act, mh_exp);
                        end
                    end
                end
                if (tlp_id_valid && tlp_id_ready) begin
                    mi_act = {tlp_id_write, tlp_id_data};
                    checks++;
                    if (id_q.size() == 0) begin
                        failures++; $display("FAIL id actual=%h required=none", mi_act);
                    end else begin
                        mi_exp = id_q.pop_front();
                        if (mi_act !== mi_exp) begin
                            failures++; $display("FAIL id actual=%h required=%h", mi_act, mi_exp);
                        end
                    end
                end
                if (tlp_d_valid && tlp_d_ready) begin
                    md_act = {tlp_d_data, tlp_d_strb, tlp_d_last};
                    checks++;
                    if (d_q.size() == 0) begin
                        failures++; $display("FAIL data actual=%h required=none", md_act);
                    end else begin
                        md_exp = d_q.pop_front();
                        if (md_act !== md_exp) begin
                            failures++; $display("FAIL data actual=%h required=%h", md_act, md_exp);
                        end
                    end
                end
                if (err_valid && err_ready) begin
                    me_act = {err_code, err_np, err_id, err_count};
                    checks++;
                    if (e_q.size() == 0) begin
                        failures++; $display("FAIL err actual=%h required=none", me_act);
                    end else begin
                        me_exp = e_q.pop_front();
                        if (me_act !== me_exp) begin
                            failures++; $display("FAIL err actual=%h required=%h", me_act, me_exp);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int snap, hs0, k;
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0; rx_last = 1'b0; rx_err = 1'b0; rx_bar = '0;
        bar_en = '1; tlp_h_ready = 1'b1; tlp_id_ready = 1'b1; tlp_d_ready = 1'b1; err_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_trans_req", 64'(trans_req), 64'd0);
        check("rst_h_valid", 64'(tlp_h_valid), 64'd0);
        check("rst_id_valid", 64'(tlp_id_valid), 64'd0);
        check("rst_d_valid", 64'(tlp_d_valid), 64'd0);
        check("rst_err_valid", 64'(err_valid), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // MWr32 len=2, BE F/3, bar0
        push_h(1'b0, 1'b1, 1'b1, 62'h400, 10'd2, 4'hF, 4'h3, 3'd0, 1'b0);
        push_d(32'h4433_2211, 4'hF, 1'b0);
        push_d(32'h8877_6655, 4'h3, 1'b1);
        pkt[0] = hdr0(1'b0, 1'b1, 5'h00, 3'd0, 1'b0, 2'd0, 10'd2);
        pkt[1] = {16'h0100, 8'h01, 4'h3, 4'hF};
        pkt[2] = 32'h0000_1000;
        pkt[3] = 32'h1122_3344;
        pkt[4] = 32'h5566_7788;
        send_pkt(5, 7'h01, 1'b0);

        // MRd64 len=1, bar2
        push_id(1'b0, {3'd2, 2'd1, 16'hABCD, 8'h12});
        push_h(1'b1, 1'b0, 1'b1, {32'h0000_0001, 30'h0800_0010}, 10'd1, 4'hF, 4'h0, 3'd2, 1'b1);
        pkt[0] = hdr0(1'b1, 1'b0, 5'h00, 3'd2, 1'b0, 2'd1, 10'd1);
        pkt[1] = {16'hABCD, 8'h12, 4'h0, 4'hF};
        pkt[2] = 32'h0000_0001;
        pkt[3] = 32'h2000_0040;
        send_pkt(4, 7'h04, 1'b0);

        // CfgRd0 register 0x10
        push_id(1'b0, {3'd0, 2'd0, 16'h0008, 8'h05});
        push_h(1'b1, 1'b0, 1'b0, 62'h4, 10'd1, 4'hF, 4'h0, 3'd7, 1'b0);
        pkt[0] = hdr0(1'b0, 1'b0, 5'h04, 3'd0, 1'b0, 2'd0, 10'd1);
        pkt[1] = {16'h0008, 8'h05, 4'h0, 4'hF};
        pkt[2] = 32'h0100_0010;
        send_pkt(3, 7'h00, 1'b0);

        // Poisoned MWr len=4 with err_ready held low
        err_ready = 1'b0;
        push_e(3'd1, 1'b0, {5'd0, 16'h1234, 8'h00}, 16'd1);
        pkt[0] = hdr0(1'b0, 1'b1, 5'h00, 3'd0, 1'b1, 2'd0, 10'd4);
        pkt[1] = {16'h1234, 8'h00, 4'hF, 4'hF};
        pkt[2] = 32'h0000_4000;
        pkt[3] = 32'hA0A0_A0A0; pkt[4] = 32'hA1A1_A1A1; pkt[5] = 32'hA2A2_A2A2; pkt[6] = 32'hA3A3_A3A3;
        send_pkt(7, 7'h01, 1'b0);

        // Msg (unsupported) must wait in H0 while the previous error is unaccepted
        push_e(3'd2, 1'b1, {5'd0, 16'h0042, 8'h07}, 16'd2);
        pkt[0] = hdr0(1'b1, 1'b0, 5'h10, 3'd0, 1'b0, 2'd0, 10'd0);
        pkt[1] = {16'h0042, 8'h07, 8'h00};
        pkt[2] = 32'h0;
        pkt[3] = 32'h0;
        snap = beats_acc;
        fork
            send_pkt(4, 7'h00, 1'b0);
        join_none
        repeat (10) @(negedge clk);
        check("h0_stall_beats", 64'(beats_acc - snap), 64'd0);
        check("err_hold_valid", 64'(err_valid), 64'd1);
        check("err_hold_code", 64'(err_code), 64'd1);
        @(posedge clk); #1;
        err_ready = 1'b1;
        wait fork;

        // MWr len=0 (1024 DW) ending at H0
        push_e(3'd3, 1'b0, 29'd0, 16'd3);
        pkt[0] = hdr0(1'b0, 1'b1, 5'h00, 3'd0, 1'b0, 2'd0, 10'd0);
        send_pkt(1, 7'h01, 1'b0);

        // MRd32 hitting disabled bar1
        bar_en = 7'b1111101;
        push_e(3'd4, 1'b1, {5'd0, 16'h0777, 8'h09}, 16'd4);
        pkt[0] = hdr0(1'b0, 1'b0, 5'h00, 3'd0, 1'b0, 2'd0, 10'd1);
        pkt[1] = {16'h0777, 8'h09, 4'h0, 4'hF};
        pkt[2] = 32'h0000_5000;
        send_pkt(3, 7'h02, 1'b0);
        bar_en = '1;

        // rx_err on a single-beat MWr
        push_e(3'd0, 1'b0, 29'd0, 16'd5);
        pkt[0] = hdr0(1'b0, 1'b1, 5'h00, 3'd0, 1'b0, 2'd0, 10'd1);
        send_pkt(1, 7'h01, 1'b1);

        // Back-to-back MRd32 with slow translation
        ack_dly = 5;
        hs0 = h_hs_cnt;
        push_id(1'b0, {5'd0, 16'h0200, 8'h20});
        push_h(1'b1, 1'b0, 1'b1, 62'h800, 10'd1, 4'hF, 4'h0, 3'd0, 1'b0);
        push_id(1'b0, {5'd0, 16'h0200, 8'h21});
        push_h(1'b1, 1'b0, 1'b1, 62'hC00, 10'd1, 4'hF, 4'h0, 3'd0, 1'b0);
        pkt[0] = hdr0(1'b0, 1'b0, 5'h00, 3'd0, 1'b0, 2'd0, 10'd1);
        pkt[1] = {16'h0200, 8'h20, 8'h0F};
        pkt[2] = 32'h0000_2000;
        send_pkt(3, 7'h01, 1'b0);
        pkt[1] = {16'h0200, 8'h21, 8'h0F};
        pkt[2] = 32'h0000_3000;
        send_pkt(3, 7'h01, 1'b0);
        check("h2_stall_hs", 64'(h_hs_cnt - hs0), 64'd1);

        k = 0;
        while ((h_q.size() + id_q.size() + d_q.size() + e_q.size()) != 0 && k < 200) begin
            k++; @(negedge clk);
        end
        check("drain", 64'(h_q.size() + id_q.size() + d_q.size() + e_q.size()), 64'd0);
        check("err_count_final", 64'(err_count), 64'd5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
